// File: rtl/xchg_reg_file_if.sv
// Bus bundle for xchg_reg_file: write port, packed read ports, exchange
// control/status and an FSM debug view. The slave modport belongs to the
// register file; the master modport belongs to whoever drives it.
interface xchg_reg_file_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_RD     = 2,
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
);
  logic                           we;
  logic [ADDR_WIDTH-1:0]          address_w;
  logic [DATA_WIDTH-1:0]          data_w;
  logic [NUM_RD*ADDR_WIDTH-1:0]   address_r;
  logic [NUM_RD*DATA_WIDTH-1:0]   data_r;
  // Exchange handshake: swap_req is level-sampled and only accepted while
  // idle; acceptance either raises swap_busy (one word pair per cycle) and
  // ends with a single-cycle swap_done, or, for overlapping ranges, gives a
  // single-cycle swap_err. swap_req is ignored while busy or done.
  logic                           swap_req;
  logic [ADDR_WIDTH-1:0]          address_A;
  logic [ADDR_WIDTH-1:0]          address_B;
  logic [LEN_WIDTH-1:0]           swap_len;
  logic                           swap_busy;
  logic                           swap_done;
  logic                           swap_err;
  logic                           wr_conflict;
  logic [CNT_WIDTH-1:0]           swap_count;
  logic [1:0]                     dbg_state;

  modport slave (
    input  we, address_w, data_w, address_r, swap_req, address_A, address_B, swap_len,
    output data_r, swap_busy, swap_done, swap_err, wr_conflict, swap_count, dbg_state
  );

  modport master (
    output we, address_w, data_w, address_r, swap_req, address_A, address_B, swap_len,
    input  data_r, swap_busy, swap_done, swap_err, wr_conflict, swap_count, dbg_state
  );
endinterface

// File: rtl/xchg_reg_file.sv
// Register file with NUM_RD combinational read ports, one synchronous write
// port and a block-exchange engine that swaps two (wrapping) address ranges
// one word pair per clock. Writes that hit the pair being exchanged in the
// current cycle are dropped and flagged on wr_conflict.
module xchg_reg_file #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_RD     = 2,
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic              clk,
  input logic              reset,
  xchg_reg_file_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XCHG = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
  logic [ADDR_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d, idx_q, idx_d;
  logic                    err_q, err_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;

  logic [ADDR_WIDTH-1:0]   cur_a, cur_b;
  logic [ADDR_WIDTH-1:0]   diff_ab, diff_ba;
  logic                    overlap;
  logic                    conflict;

  // Addresses of the word pair handled this cycle; wrap naturally modulo depth.
  assign cur_a = a_q + ADDR_WIDTH'(idx_q);
  assign cur_b = b_q + ADDR_WIDTH'(idx_q);

  // Two ranges of L+1 words overlap iff either base lies within L words
  // (modulo depth) after the other; this also catches A == B.
  assign diff_ab = bus.address_B - bus.address_A;
  assign diff_ba = bus.address_A - bus.address_B;
  assign overlap = (32'(diff_ab) <= 32'(bus.swap_len)) ||
                   (32'(diff_ba) <= 32'(bus.swap_len));

  // The exchange owns the current pair; a write aimed at it is dropped.
  assign conflict = bus.we && (state_q == ST_XCHG) &&
                    ((bus.address_w == cur_a) || (bus.address_w == cur_b));

  assign bus.wr_conflict = conflict;
  assign bus.swap_busy   = (state_q == ST_XCHG);
  assign bus.swap_done   = (state_q == ST_DONE);
  assign bus.swap_err    = err_q;
  assign bus.swap_count  = count_q;
  assign bus.dbg_state   = state_q;

  // Combinational read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    assign bus.data_r[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[bus.address_r[k*ADDR_WIDTH +: ADDR_WIDTH]];
  end

  // Next-state logic for the exchange FSM, latched request and counters.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    len_d   = len_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    count_d = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.swap_req) begin
          a_d   = bus.address_A;
          b_d   = bus.address_B;
          len_d = bus.swap_len;
          idx_d = '0;
          if (overlap) err_d = 1'b1;
          else         state_d = ST_XCHG;
        end
      end
      ST_XCHG: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == len_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        count_d = count_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next memory image: ordinary write, then the exchange pair overrides it.
  always_comb begin
    mem_d = mem_q;
    if (bus.we && !conflict) mem_d[bus.address_w] = bus.data_w;
    if (state_q == ST_XCHG) begin
      mem_d[cur_a] = mem_q[cur_b];
      mem_d[cur_b] = mem_q[cur_a];
    end
  end

  // State registers; reset clears every word and abandons any exchange.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end
endmodule
